// File: rtl/ibm_fetch_pkg.sv
// Shared types and constants for the IBM core instruction fetch path.
// Optional 2-entry prefetch is selected in instr_fetch by FETCH_PREFETCH_EN.
package ibm_fetch_pkg;
  typedef enum logic [1:0] {FETCH, FULL, DRAIN} fetch_state_e;

  localparam logic [15:0] FETCH_RESET_PC = 16'h0000;
  // Opcode of the register jump; execute raises REDIRECT when it retires one
  localparam logic [4:0]  OP_JMR         = 5'b11100;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
  } fetch_ent_t;
endpackage

// File: rtl/fetch_buffer.sv
// Shift-style FIFO of {addr, data} fetch entries, depth 1 or 2.
// Flush clears occupancy and overrides any same-cycle write or take.
module fetch_buffer import ibm_fetch_pkg::*; #(
  parameter int          DEPTH      = 1,
  parameter logic [15:0] RESET_ADDR = 16'h0000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr,
  input  fetch_ent_t wr_ent,
  input  logic       take,
  input  logic       flush,
  output fetch_ent_t head,
  output logic       valid,
  output logic [1:0] occ
);
  fetch_ent_t [DEPTH-1:0] ent_q, ent_d;
  logic [1:0] occ_q, occ_d;
  logic       take_ok;
  logic [1:0] wr_idx;

  assign take_ok = take & (occ_q != 2'd0);
  // A write lands behind whatever survives this cycle's take
  assign wr_idx  = occ_q - {1'b0, take_ok};

  always_comb begin
    ent_d = ent_q;
    occ_d = occ_q;
    if (flush) begin
      occ_d = 2'd0;
    end else begin
      if (take_ok)
        for (int i = 0; i < DEPTH-1; i++) ent_d[i] = ent_q[i+1];
      if (wr)
        for (int i = 0; i < DEPTH; i++)
          if (wr_idx == i[1:0]) ent_d[i] = wr_ent;
      occ_d = occ_q + {1'b0, wr} - {1'b0, take_ok};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '{addr: RESET_ADDR, data: 16'h0000};
      occ_q <= 2'd0;
    end else begin
      ent_q <= ent_d;
      occ_q <= occ_d;
    end
  end

  assign head  = ent_q[0];
  assign valid = (occ_q != 2'd0);
  assign occ   = occ_q;
endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: PC sequencing, memory req/ack handshake, redirect/drain.
// Define FETCH_PREFETCH_EN for a 2-entry prefetch buffer (default: 1 entry).
module instr_fetch import ibm_fetch_pkg::*; #(
  parameter logic [15:0] RESET_PC = FETCH_RESET_PC
) (
  input  logic        CLOCK,
  input  logic        RESETN,
  output logic        MEM_REQ,
  output logic [15:0] MEM_ADDR,
  input  logic        MEM_ACK,
  input  logic [15:0] MEM_RDATA,
  output logic [15:0] INSTR,
  output logic        INSTR_VALID,
  input  logic        INSTR_TAKE,
  output logic [15:0] PC_OUT,
  input  logic        REDIRECT,
  input  logic [15:0] REDIRECT_ADDR
);
`ifdef FETCH_PREFETCH_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif
  localparam logic [1:0] DEPTH_W = 2'(DEPTH);

  fetch_state_e state_q, state_d;
  logic         req_q, req_d;
  logic [15:0]  addr_q, addr_d, tgt_q, tgt_d;
  logic         ack, pending, buf_wr, buf_take;
  logic [1:0]   occ, occ_nx;
  fetch_ent_t   head;

  assign ack      = req_q & MEM_ACK;
  assign pending  = req_q & ~MEM_ACK;
  assign buf_wr   = ack & ~REDIRECT & (state_q != DRAIN);
  assign buf_take = INSTR_TAKE & INSTR_VALID;
  assign occ_nx   = occ + {1'b0, buf_wr} - {1'b0, buf_take};

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    tgt_d   = tgt_q;
    if (REDIRECT) begin
      tgt_d = REDIRECT_ADDR;
      if (pending) begin
        // Old request must complete on its own address before we move on
        state_d = DRAIN;
      end else begin
        state_d = FETCH;
        req_d   = 1'b1;
        addr_d  = REDIRECT_ADDR;
      end
    end else if (state_q == DRAIN) begin
      if (ack) begin
        state_d = FETCH;
        req_d   = 1'b1;
        addr_d  = tgt_q;
      end
    end else begin
      if (ack) addr_d = addr_q + 16'd1;
      // An outstanding request is always held; a new one only if a slot is free
      req_d   = pending | (occ_nx < DEPTH_W);
      state_d = req_d ? FETCH : FULL;
    end
  end

  always_ff @(posedge CLOCK or negedge RESETN) begin
    if (!RESETN) begin
      state_q <= FETCH;
      req_q   <= 1'b0;
      addr_q  <= RESET_PC;
      tgt_q   <= RESET_PC;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      tgt_q   <= tgt_d;
    end
  end

  fetch_buffer #(.DEPTH(DEPTH), .RESET_ADDR(RESET_PC)) u_buf (
    .clk   (CLOCK),
    .rst_n (RESETN),
    .wr    (buf_wr),
    .wr_ent('{addr: addr_q, data: MEM_RDATA}),
    .take  (buf_take),
    .flush (REDIRECT),
    .head  (head),
    .valid (INSTR_VALID),
    .occ   (occ)
  );

  assign MEM_REQ  = req_q;
  assign MEM_ADDR = addr_q;
  assign INSTR    = head.data;
  assign PC_OUT   = head.addr;
endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: scoreboard of expected PCs plus timing checks.
module tb_instr_fetch;
`ifdef FETCH_PREFETCH_EN
  localparam int D = 2;
`else
  localparam int D = 1;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, mem_req, mem_ack, instr_valid, take, redir;
  logic [15:0] mem_addr, rdata, instr, pc_out, redir_addr;
  logic        rst2_n, req2, ack2, valid2, take2, redir2;
  logic [15:0] addr2, rdata2, instr2, pc2, raddr2;

  int tests_run = 0, tests_failed = 0;
  int lat = 0, wcnt = 0, cyc = 0;
  logic [15:0] exp_q[$];

  instr_fetch u0 (
    .CLOCK(clk), .RESETN(rst_n), .MEM_REQ(mem_req), .MEM_ADDR(mem_addr),
    .MEM_ACK(mem_ack), .MEM_RDATA(rdata), .INSTR(instr), .INSTR_VALID(instr_valid),
    .INSTR_TAKE(take), .PC_OUT(pc_out), .REDIRECT(redir), .REDIRECT_ADDR(redir_addr)
  );

  instr_fetch #(.RESET_PC(16'hFFFF)) u1 (
    .CLOCK(clk), .RESETN(rst2_n), .MEM_REQ(req2), .MEM_ADDR(addr2),
    .MEM_ACK(ack2), .MEM_RDATA(rdata2), .INSTR(instr2), .INSTR_VALID(valid2),
    .INSTR_TAKE(take2), .PC_OUT(pc2), .REDIRECT(redir2), .REDIRECT_ADDR(raddr2)
  );

  // Memory model for u0: ack after `lat` wait cycles, data = addr ^ A5A5
  initial begin
    mem_ack = 1'b0;
    rdata   = 16'h0000;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (mem_req) begin
        if (wcnt >= lat) begin
          mem_ack = 1'b1; rdata = mem_addr ^ 16'hA5A5; wcnt = 0;
        end else begin
          mem_ack = 1'b0; rdata = 16'hDEAD; wcnt++;
        end
      end else begin
        mem_ack = 1'b0; wcnt = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic step;
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset;
    repeat (2) step;
    tests_run++;
    if ({mem_req, instr_valid} !== 2'b00) begin
      tests_failed++; $display("FAIL reset_req_valid: got %b want 00", {mem_req, instr_valid});
    end
    tests_run++;
    if ({mem_addr, instr, pc_out} !== 48'h0) begin
      tests_failed++; $display("FAIL reset_values: got %h want 0", {mem_addr, instr, pc_out});
    end
    rst_n = 1'b1;
    step;
    tests_run++;
    if (mem_req !== 1'b1 || mem_addr !== 16'h0000) begin
      tests_failed++; $display("FAIL first_req: got req=%b addr=%h want req=1 addr=0000", mem_req, mem_addr);
    end
  endtask

  task automatic test_no_take;
    logic [15:0] seen[$];
    for (int a = 0; a < D; a++) exp_q.push_back(16'(a));
    for (int i = 0; i < 8; i++) begin
      if (mem_req && mem_ack) seen.push_back(mem_addr);
      step;
    end
    tests_run++;
    if (seen.size() != D) begin
      tests_failed++; $display("FAIL no_take_fetch_count: got %0d want %0d", seen.size(), D);
    end
    for (int k = 0; k < seen.size(); k++) begin
      tests_run++;
      if (seen[k] !== 16'(k)) begin
        tests_failed++; $display("FAIL no_take_addr%0d: got %h want %h", k, seen[k], 16'(k));
      end
    end
    tests_run++;
    if ({mem_req, instr_valid, instr, pc_out} !== {1'b0, 1'b1, 16'hA5A5, 16'h0000}) begin
      tests_failed++;
      $display("FAIL no_take_hold: got req=%b v=%b instr=%h pc=%h want 0 1 a5a5 0000",
               mem_req, instr_valid, instr, pc_out);
    end
  endtask

  task automatic test_stream;
    int t[6];
    int got = 0, budget = 0;
    logic [15:0] e;
    for (int a = D; a < 6; a++) exp_q.push_back(16'(a));
    take = 1'b1;
    while (got < 6 && budget < 60) begin
      if (instr_valid) begin
        e = exp_q.pop_front();
        tests_run++;
        if (pc_out !== e || instr !== (e ^ 16'hA5A5)) begin
          tests_failed++; $display("FAIL stream_word: got pc=%h instr=%h want pc=%h", pc_out, instr, e);
        end
        t[got] = cyc;
        got++;
      end
      step;
      budget++;
    end
    take = 1'b0;
    tests_run++;
    if (got != 6) begin
      tests_failed++; $display("FAIL stream_timeout: got %0d words want 6", got);
    end else begin
      tests_run++;
      if (t[5] - t[4] != 3 - D || t[4] - t[3] != 3 - D) begin
        tests_failed++;
        $display("FAIL stream_rate: got gaps %0d %0d want %0d", t[4] - t[3], t[5] - t[4], 3 - D);
      end
    end
  endtask

  task automatic test_ack_delay;
    logic pend;
    int budget = 0;
    lat = 3;
    exp_q.delete();
    exp_q.push_back(16'h0010);
    pend = mem_req && !mem_ack;
    redir = 1'b1; redir_addr = 16'h0010;
    step;
    redir = 1'b0;
    tests_run++;
    if (instr_valid !== 1'b0) begin
      tests_failed++; $display("FAIL redirect_valid_drop: got %b want 0", instr_valid);
    end
    if (!pend) begin
      tests_run++;
      if (mem_req !== 1'b1 || mem_addr !== 16'h0010) begin
        tests_failed++; $display("FAIL redirect_addr: got req=%b addr=%h want 1 0010", mem_req, mem_addr);
      end
    end
    while (!(mem_req && mem_addr == 16'h0010) && budget < 20) begin step; budget++; end
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if ({mem_req, mem_ack, instr_valid, mem_addr} !== {3'b100, 16'h0010}) begin
        tests_failed++;
        $display("FAIL ack_wait%0d: got req=%b ack=%b v=%b addr=%h want 1 0 0 0010",
                 i, mem_req, mem_ack, instr_valid, mem_addr);
      end
      step;
    end
    tests_run++;
    if (mem_ack !== 1'b1 || instr_valid !== 1'b0) begin
      tests_failed++; $display("FAIL ack_cycle: got ack=%b v=%b want 1 0", mem_ack, instr_valid);
    end
    step;
    tests_run++;
    if (instr_valid !== 1'b1 || pc_out !== exp_q[0] || instr !== (exp_q[0] ^ 16'hA5A5)) begin
      tests_failed++;
      $display("FAIL ack_to_valid: got v=%b pc=%h instr=%h want 1 %h", instr_valid, pc_out, instr, exp_q[0]);
    end
    void'(exp_q.pop_front());
  endtask

  task automatic test_redirect_drain;
    int budget = 0;
    lat = 2;
    redir = 1'b1; redir_addr = 16'h0003;
    step;
    redir = 1'b0;
    while (!(mem_req && mem_addr == 16'h0003) && budget < 20) begin step; budget++; end
    exp_q.delete();
    exp_q.push_back(16'h0040);
    tests_run++;
    if (mem_ack !== 1'b0 || mem_addr !== 16'h0003) begin
      tests_failed++; $display("FAIL drain_setup: got ack=%b addr=%h want 0 0003", mem_ack, mem_addr);
    end
    redir = 1'b1; redir_addr = 16'h0030;
    step;
    redir_addr = 16'h0040;
    tests_run++;
    if ({mem_req, instr_valid, mem_addr} !== {2'b10, 16'h0003}) begin
      tests_failed++; $display("FAIL drain_hold: got req=%b v=%b addr=%h want 1 0 0003", mem_req, instr_valid, mem_addr);
    end
    step;
    redir = 1'b0;
    tests_run++;
    if (mem_ack !== 1'b1 || mem_addr !== 16'h0003) begin
      tests_failed++; $display("FAIL drain_ack: got ack=%b addr=%h want 1 0003", mem_ack, mem_addr);
    end
    step;
    tests_run++;
    if (mem_req !== 1'b1 || mem_addr !== 16'h0040 || instr_valid !== 1'b0) begin
      tests_failed++; $display("FAIL drain_target: got req=%b addr=%h v=%b want 1 0040 0", mem_req, mem_addr, instr_valid);
    end
    budget = 0;
    while (!instr_valid && budget < 20) begin step; budget++; end
    tests_run++;
    if (instr_valid !== 1'b1 || pc_out !== exp_q[0] || instr !== (exp_q[0] ^ 16'hA5A5)) begin
      tests_failed++; $display("FAIL drain_first_valid: got v=%b pc=%h want 1 %h", instr_valid, pc_out, exp_q[0]);
    end
    void'(exp_q.pop_front());
  endtask

  task automatic test_redirect_take_ack;
    int got = 0, budget = 0;
    logic [15:0] e;
    lat = 0;
    exp_q.delete();
    for (int a = 16'h40; a < 16'h48; a++) exp_q.push_back(16'(a));
    take = 1'b1;
    while (budget < 40) begin
      if (got >= 2 && mem_req && mem_ack && (D == 1 || instr_valid)) break;
      if (instr_valid) begin
        e = exp_q.pop_front();
        tests_run++;
        if (pc_out !== e) begin
          tests_failed++; $display("FAIL rta_stream: got pc=%h want %h", pc_out, e);
        end
        got++;
      end
      step;
      budget++;
    end
    tests_run++;
    if (budget >= 40) begin
      tests_failed++; $display("FAIL rta_setup_timeout: got %0d cycles want <40", budget);
    end
    exp_q.delete();
    exp_q.push_back(16'h0100);
    redir = 1'b1; redir_addr = 16'h0100;
    step;
    redir = 1'b0; take = 1'b0;
    tests_run++;
    if ({instr_valid, mem_req, mem_addr} !== {2'b01, 16'h0100}) begin
      tests_failed++; $display("FAIL rta_flush: got v=%b req=%b addr=%h want 0 1 0100", instr_valid, mem_req, mem_addr);
    end
    step;
    step;
    tests_run++;
    if (instr_valid !== 1'b1 || pc_out !== exp_q[0]) begin
      tests_failed++; $display("FAIL rta_restart: got v=%b pc=%h want 1 %h", instr_valid, pc_out, exp_q[0]);
    end
    void'(exp_q.pop_front());
  endtask

  task automatic test_reset_ffff;
    tests_run++;
    if ({req2, valid2, addr2, pc2, instr2} !== {2'b00, 16'hFFFF, 16'hFFFF, 16'h0000}) begin
      tests_failed++; $display("FAIL ffff_reset: got req=%b v=%b addr=%h pc=%h instr=%h", req2, valid2, addr2, pc2, instr2);
    end
    rst2_n = 1'b1;
    step;
    tests_run++;
    if (req2 !== 1'b1 || addr2 !== 16'hFFFF) begin
      tests_failed++; $display("FAIL ffff_first: got req=%b addr=%h want 1 ffff", req2, addr2);
    end
    ack2 = 1'b1; rdata2 = 16'h1234;
    step;
    ack2 = 1'b0;
    tests_run++;
    if (valid2 !== 1'b1 || pc2 !== 16'hFFFF || instr2 !== 16'h1234) begin
      tests_failed++; $display("FAIL ffff_word: got v=%b pc=%h instr=%h want 1 ffff 1234", valid2, pc2, instr2);
    end
    take2 = 1'b1;
    step;
    take2 = 1'b0;
    tests_run++;
    if (req2 !== 1'b1 || addr2 !== 16'h0000) begin
      tests_failed++; $display("FAIL ffff_wrap: got req=%b addr=%h want 1 0000", req2, addr2);
    end
    #2;
    rst2_n = 1'b0;
    #1;
    tests_run++;
    if ({req2, valid2, addr2, pc2, instr2} !== {2'b00, 16'hFFFF, 16'hFFFF, 16'h0000}) begin
      tests_failed++; $display("FAIL async_reset: got req=%b v=%b addr=%h pc=%h instr=%h", req2, valid2, addr2, pc2, instr2);
    end
  endtask

  initial begin
    rst_n = 1'b0; take = 1'b0; redir = 1'b0; redir_addr = 16'h0000;
    rst2_n = 1'b0; ack2 = 1'b0; rdata2 = 16'h0000; take2 = 1'b0; redir2 = 1'b0; raddr2 = 16'h0000;
    test_reset;
    test_no_take;
    test_stream;
    test_ack_delay;
    test_redirect_drain;
    test_redirect_take_ack;
    test_reset_ffff;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
